pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Supports a configurable width, reset vector and step size.
- Provides absolute, PC-relative, return and trap redirects, plus a circular return-address stack (RAS) and misaligned-target detection.
- Sits between the branch/jump resolution logic and instruction fetch; `pc` drives the fetch address.

Parameters:
- XLEN, 32, datapath and PC width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- STEP, 4, increment per count cycle; also the alignment requirement (power of two).
- RAS_DEPTH, 4, return-address-stack entries (power of two, at least 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 => reset).
- count  in  1  1 => advance PC by STEP.
- stall  in  1  1 => hold PC (blocks count only).
- redirect  in  1  1 => load a new PC this cycle.
- mode  in  2  redirect kind: 00 absolute, 01 relative, 10 return, 11 trap.
- call  in  1  with redirect: push the return address onto the RAS.
- data_in  in  XLEN  absolute target, signed offset, or return fallback, depending on mode.
- trap_vector  in  XLEN  target for mode 11 and for misaligned redirects.
- pc  out  XLEN  current PC (registered).
- misaligned  out  1  one-cycle pulse: the last redirect target was misaligned.
- ras_underflow  out  1  one-cycle pulse: a return was issued with the RAS empty.
- ras_empty  out  1  RAS holds no entries (combinational from the count).
- ras_full  out  1  RAS count equals RAS_DEPTH.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - pc <= RESET_VECTOR.
  - RAS pointer and count <= 0.
  - misaligned and ras_underflow <= 0.
  - Reset overrides all other inputs, including mid-redirect; RAS contents are don't-care.
- Priority is reset > redirect > stall > count > hold.
  - Redirect takes effect even while stall = 1.
  - With stall = 1 and redirect = 0, pc holds regardless of count.
  - With count = 1 and no stall: pc <= pc + STEP, modulo 2^XLEN (wraps from all-ones region to low).
- Raw target by mode, all arithmetic XLEN bits modulo 2^XLEN:
  - 00: data_in.
  - 01: pc + signed(data_in) − STEP. The offset is relative to the instruction one step behind the current PC, because fetch has already advanced.
  - 10: RAS top entry if the RAS is non-empty; otherwise data_in, and ras_underflow pulses for 1 cycle.
  - 11: trap_vector.
- Alignment:
  - If the raw target mod STEP != 0, pc <= trap_vector and misaligned pulses for one cycle.
  - On a misaligned redirect, no RAS push or pop takes effect.
  - trap_vector itself is never checked.
- RAS push (redirect with call = 1, target aligned):
  - Pushes the current pc, which is the return address.
  - If full, the push overwrites the oldest entry (circular) and count stays at RAS_DEPTH.
- RAS pop: mode 10 with RAS non-empty pops the top entry (count − 1).
- Mode 10 with call = 1 (co-routine swap):
  - Pop first (target = old top), then push the current pc.
  - Count is unchanged; with an empty RAS it is push-only and ras_underflow pulses.
- Mode 11 with call = 1: the push happens (trap entry is treated like a call).
- Latency:
  - All updates take effect one cycle after the inputs are sampled.
  - pc is visible on the cycle after the edge.
  - There is no combinational path from any input to pc.
- Pulses last exactly one cycle and are cleared on the next edge unless re-triggered.

Test Plan:
- Reset and count: reset = 0 for 2 cycles, RESET_VECTOR = 0x100 → pc = 0x100. Release; count = 1 for 3 cycles → pc = 0x10C. Then stall = 1 with count = 1 → pc holds 0x10C.
- Relative and absolute: pc = 0x200; redirect with mode 01, data_in = 0xFFFFFFF0 (−16) → pc = 0x1EC. Then mode 00, data_in = 0x400 → pc = 0x400, even with stall = 1.
- Call/return: at pc = 0x1000, redirect with mode 00, call = 1, data_in = 0x2000 → pc = 0x2000, ras_empty = 0. Then mode 10 → pc = 0x1000, ras_empty = 1.
- RAS overflow and underflow: 5 calls with RAS_DEPTH = 4 → ras_full = 1. The 4 returns yield the last 4 pushed addresses, newest first. A 5th return with data_in = 0x80 → pc = 0x80, ras_underflow pulses once.
- Misaligned: trap_vector = 0x40; redirect with mode 00, data_in = 0x302, call = 1 → pc = 0x40, misaligned high for 1 cycle, RAS count unchanged.
- Wrap and reset mid-op: pc = 0xFFFFFFFC, count → pc = 0. Assert reset during a redirect → pc = RESET_VECTOR, ras_empty = 1, both pulses 0.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter with absolute/relative/return/trap redirects and a circular RAS.
// Latency: all outputs registered, one cycle after inputs are sampled (ras_empty/ras_full decode the registered count).
// Backpressure: stall holds pc against count only; redirect and reset always take effect.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            count,
    input  logic            stall,
    input  logic            redirect,
    input  logic [1:0]      mode,
    input  logic            call,
    input  logic [XLEN-1:0] data_in,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc,
    output logic            misaligned,
    output logic            ras_underflow,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int              PW         = $clog2(RAS_DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

    localparam logic [1:0] MODE_ABS = 2'b00;
    localparam logic [1:0] MODE_REL = 2'b01;
    localparam logic [1:0] MODE_RET = 2'b10;
    localparam logic [1:0] MODE_TRP = 2'b11;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;     // next free slot; top of stack is ras_ptr-1
    logic [CW-1:0]   ras_cnt;

    logic [PW-1:0]   top_idx;
    logic [PW-1:0]   wr_idx;
    logic            ras_has;
    logic [XLEN-1:0] raw_target;
    logic            mis_nxt;
    logic            uf_nxt;
    logic            do_push;
    logic            do_pop;
    logic [XLEN-1:0] pc_nxt;
    logic [PW-1:0]   ptr_nxt;
    logic [CW-1:0]   cnt_nxt;

    always_comb begin
        top_idx    = ras_ptr - PW'(1);
        ras_has    = (ras_cnt != '0);
        raw_target = data_in;
        case (mode)
            MODE_ABS: raw_target = data_in;
            MODE_REL: raw_target = pc + data_in - STEP_X;
            MODE_RET: raw_target = ras_has ? ras_mem[top_idx] : data_in;
            MODE_TRP: raw_target = trap_vector;
            default:  raw_target = data_in;
        endcase

        // the trap vector is trusted, so mode 11 never flags misalignment
        mis_nxt = redirect && (mode != MODE_TRP) && ((raw_target & ALIGN_MASK) != '0);
        uf_nxt  = redirect && (mode == MODE_RET) && !ras_has;
        do_push = redirect && call && !mis_nxt;
        do_pop  = redirect && (mode == MODE_RET) && ras_has && !mis_nxt;

        if (redirect)
            pc_nxt = mis_nxt ? trap_vector : raw_target;
        else if (stall)
            pc_nxt = pc;
        else if (count)
            pc_nxt = pc + STEP_X;
        else
            pc_nxt = pc;

        // a swap (pop+push) rewrites the old top in place
        wr_idx  = do_pop ? top_idx : ras_ptr;
        ptr_nxt = ras_ptr;
        cnt_nxt = ras_cnt;
        if (do_push && !do_pop) begin
            ptr_nxt = ras_ptr + PW'(1);
            if (ras_cnt != CW'(RAS_DEPTH))
                cnt_nxt = ras_cnt + CW'(1);
        end else if (do_pop && !do_push) begin
            ptr_nxt = top_idx;
            cnt_nxt = ras_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc            <= RESET_VECTOR;
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            misaligned    <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_nxt;
            ras_ptr       <= ptr_nxt;
            ras_cnt       <= cnt_nxt;
            misaligned    <= mis_nxt;
            ras_underflow <= uf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push)
            ras_mem[wr_idx] <= pc;
    end

    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));

endmodule
